ofifo_drain_ctrl: RTL and testbench
===================================

Name: ofifo_drain_ctrl

Overview:
- Downstream stage of the corelet OFIFO.
- Drains completed psum vectors (col x psum_bw) from the OFIFO and writes them to consecutive addresses of the psum SRAM.
- Each drain job is started by `start` and covers `num_vec` vectors. The block raises `done` at the end; the top level can then begin the acc/SFP pass.
- Sits between the corelet `ofifo_out`/`ofifo_rd` and the psum memory write port.

Parameters:
- col, 8, number of columns (psum lanes per vector)
- psum_bw, 16, bits per psum lane
- addr_bw, 11, psum SRAM address width

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  one-cycle pulse; launches a drain job (ignored unless IDLE)
- base_addr  input  addr_bw  first SRAM address of the job, sampled on accepted start
- num_vec  input  addr_bw  vectors to drain, sampled on accepted start; 0 = no-op job
- ofifo_valid  input  1  OFIFO holds at least one full vector
- ofifo_out  input  col*psum_bw  OFIFO head vector, combinational from read pointer
- ofifo_rd  output  1  pop OFIFO head this cycle
- pmem_stall  input  1  psum SRAM cannot accept a write this cycle
- pmem_wr  output  1  SRAM write strobe
- pmem_addr  output  addr_bw  SRAM write address
- pmem_din  output  col*psum_bw  SRAM write data
- busy  output  1  job in progress (state != IDLE)
- done  output  1  one-cycle pulse when the last write has been issued

Behaviour:
- Reset (reset=0, async): state=IDLE. ofifo_rd, pmem_wr, done, busy = 0. pmem_addr, pmem_din, vec counter = 0.
- States: IDLE, DRAIN, FLUSH, FINISH.
- IDLE:
  - start=1 and num_vec!=0 -> latch base_addr and num_vec, clear count, go to DRAIN.
  - start=1 and num_vec=0 -> go to FINISH directly; no reads, no writes.
- DRAIN:
  - ofifo_rd = ofifo_valid & ~pmem_stall & (count < num_vec) & ~wb_pending_blocked.
  - A pop captures ofifo_out into the write-data register. On the next cycle: pmem_wr=1, pmem_addr=base_addr+index, pmem_din = captured word.
  - Fixed latency of 1 cycle from pop to write strobe.
  - Sustained throughput: 1 vector/cycle when ofifo_valid=1 and pmem_stall=0.
- Stall:
  - While pmem_stall=1, no pop is issued.
  - A pending write holds pmem_wr=1 and keeps pmem_addr/pmem_din stable until a cycle with pmem_stall=0.
  - wb_pending_blocked = a pending write exists and pmem_stall=1.
- Count and transition to FLUSH: count increments on each pop. When the pop with count = num_vec-1 occurs, go to FLUSH.
- FLUSH:
  - Complete the final pending write (honouring pmem_stall), then go to FINISH.
  - ofifo_rd=0.
- FINISH: done=1 for exactly one cycle, then go to IDLE. busy=0 in IDLE only.
- Address arithmetic: addresses wrap modulo 2^addr_bw (base_addr+num_vec-1 may wrap past the maximum address to 0).
- ofifo_valid=0 in DRAIN: wait indefinitely; no timeout.
- start while busy: ignored; the running job is unaffected.
- Invariants:
  - ofifo_rd is never asserted outside DRAIN or when ofifo_valid=0.
  - No more than num_vec pops occur per job.
- Reset mid-job: immediate return to IDLE with all outputs 0. An in-flight captured word is discarded and no done is issued.

Optional Feature:
- Macro: OFIFO_DRAIN_CHECKSUM_EN.
- When defined:
  - Extra output port `checksum`, width psum_bw, reset 0.
  - Cleared on an accepted start.
  - On every issued write (pmem_wr=1 & pmem_stall=0), XORs in the XOR-fold of the col lanes of pmem_din.
  - Final value is valid in the done cycle and holds until the next start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic drain:
  - Stimulus: base_addr=0x010, num_vec=4; OFIFO holds vectors whose every lane = 1,2,3,4; ofifo_valid constant; pmem_stall=0.
  - Required: 4 consecutive ofifo_rd cycles; writes to 0x010-0x013 with matching data, each 1 cycle after its pop; done exactly 1 cycle after the FLUSH write cycle; busy low afterwards.
- Stall:
  - Stimulus: num_vec=3; pmem_stall=1 for 2 cycles after the first write strobe.
  - Required: pmem_wr/pmem_addr/pmem_din held stable 3 cycles; no pop during stall; totals 3 pops, 3 writes.
- Bubbles:
  - Stimulus: ofifo_valid toggles 1,0,0,1,0,1; num_vec=3.
  - Required: pops only on valid cycles; addresses contiguous; done after the third write.
- Wrap and zero job:
  - Stimulus: addr_bw=11, base_addr=0x7FE, num_vec=3.
  - Required: write addresses 0x7FE, 0x7FF, 0x000.
  - Stimulus: num_vec=0.
  - Required: no rd or wr; done pulses 1 cycle after start.
- Reset and ignored start:
  - Stimulus: reset asserted mid-job after 2 of 5 pops.
  - Required: all outputs 0 immediately; no done.
  - Stimulus: start pulse during busy.
  - Required: ignored; the running job completes with the original num_vec.
- Checksum (OFIFO_DRAIN_CHECKSUM_EN):
  - Stimulus: 2 vectors, all lanes 0x0003 then 0x0005.
  - Required: checksum = 0x0000 XOR-fold (8 equal lanes fold to 0).
  - Stimulus: vector with lane0=0x00F0, other lanes 0.
  - Required: checksum = 0x00F0.

Source files
------------

// File: rtl/ofifo_drain_ctrl.sv
// Drains psum vectors from the corelet OFIFO into consecutive psum SRAM addresses.
// Optional running XOR checksum of written data: define OFIFO_DRAIN_CHECKSUM_EN.
`timescale 1ns/1ps
module ofifo_drain_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic [addr_bw-1:0]       num_vec,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    input  logic                     pmem_stall,
    output logic                     pmem_wr,
    output logic [addr_bw-1:0]       pmem_addr,
    output logic [col*psum_bw-1:0]   pmem_din,
    output logic                     busy,
`ifdef OFIFO_DRAIN_CHECKSUM_EN
    output logic [psum_bw-1:0]       checksum,
`endif
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        FINISH
    } state_t;

    state_t             state;
    logic [addr_bw-1:0] base_r;
    logic [addr_bw-1:0] num_r;
    logic [addr_bw-1:0] count;
    logic               wb_pending_blocked;
    logic               write_issued;
    logic               pop;

    assign wb_pending_blocked = pmem_wr & pmem_stall;
    assign write_issued       = pmem_wr & ~pmem_stall;

    // The pop must be combinational: ofifo_out is the live head and is captured on the same edge.
    assign pop = (state == DRAIN) & ofifo_valid & ~pmem_stall & (count < num_r) & ~wb_pending_blocked;
    assign ofifo_rd = pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base_r    <= '0;
            num_r     <= '0;
            count     <= '0;
            pmem_wr   <= 1'b0;
            pmem_addr <= '0;
            pmem_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (write_issued)
                pmem_wr <= 1'b0;
            // A pop only happens in a non-stalled cycle, so any older pending write retires on this edge.
            if (pop) begin
                pmem_wr   <= 1'b1;
                pmem_addr <= base_r + count;
                pmem_din  <= ofifo_out;
                count     <= count + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_vec != '0) begin
                            base_r <= base_addr;
                            num_r  <= num_vec;
                            count  <= '0;
                            state  <= DRAIN;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (count == num_r - 1'b1))
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (write_issued) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OFIFO_DRAIN_CHECKSUM_EN
    logic [psum_bw-1:0] lane_fold;

    always_comb begin
        lane_fold = '0;
        for (int unsigned i = 0; i < col; i++)
            lane_fold = lane_fold ^ pmem_din[i*psum_bw +: psum_bw];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            checksum <= '0;
        else if ((state == IDLE) && start)
            checksum <= '0;
        else if (write_issued)
            checksum <= checksum ^ lane_fold;
    end
`endif

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Bench for ofifo_drain_ctrl: queue-based drain model checked every cycle, plus per-job literal expectations.
`timescale 1ns/1ps
module tb_ofifo_drain_ctrl;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int ABW = 11;
    localparam int DW  = COL * PBW;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [ABW-1:0] base_addr;
    logic [ABW-1:0] num_vec;
    logic           ofifo_valid;
    logic [DW-1:0]  ofifo_out;
    logic           ofifo_rd;
    logic           pmem_stall;
    logic           pmem_wr;
    logic [ABW-1:0] pmem_addr;
    logic [DW-1:0]  pmem_din;
    logic           busy;
    logic           done;
`ifdef OFIFO_DRAIN_CHECKSUM_EN
    logic [PBW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    ofifo_drain_ctrl #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_vec(num_vec),
        .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
        .pmem_stall(pmem_stall), .pmem_wr(pmem_wr), .pmem_addr(pmem_addr), .pmem_din(pmem_din),
        .busy(busy),
`ifdef OFIFO_DRAIN_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done(done)
    );

    // OFIFO stand-in: head moves on the edge after ofifo_rd, via NBA so the DUT samples the old head.
    logic [DW-1:0] fifo_mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            pops_seen = 0;
    logic          valid_en;

    assign ofifo_valid = valid_en && (wr_ptr != rd_ptr);
    assign ofifo_out   = fifo_mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (ofifo_rd) begin
            rd_ptr    <= rd_ptr + 1;
            pops_seen <= pops_seen + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PBW-1:0] fold(input logic [DW-1:0] v);
        logic [PBW-1:0] f;
        f = '0;
        for (int i = 0; i < COL; i++) f = f ^ v[i*PBW +: PBW];
        return f;
    endfunction

    function automatic logic [DW-1:0] lanes(input logic [PBW-1:0] x);
        logic [DW-1:0] v;
        for (int i = 0; i < COL; i++) v[i*PBW +: PBW] = x;
        return v;
    endfunction

    // Model: a job is (base, n); each accepted pop queues the write it owes; a queued write is
    // strobed until a non-stalled cycle retires it; done follows the cycle that retires the last one.
    typedef struct {
        logic [ABW-1:0] addr;
        logic [DW-1:0]  data;
    } wr_t;

    wr_t            m_pend[$];
    bit             m_active, m_busy, m_done;
    int             m_pops, m_n;
    logic [ABW-1:0] m_base;
    logic [PBW-1:0] m_cks;

    logic [ABW-1:0] wlog_addr[$];
    logic [DW-1:0]  wlog_data[$];
    int             done_cnt  = 0;
    int             wr_hi_cnt = 0;
    logic [PBW-1:0] done_cks  = '0;
    bit             chk_en    = 1'b0;

    always @(negedge clk) begin : cmp
        bit  exp_rd, acc;
        wr_t w;
        if (chk_en) begin
            if (!reset) begin
                check("rst_ofifo_rd", ofifo_rd, 0);
                check("rst_pmem_wr", pmem_wr, 0);
                check("rst_pmem_addr", pmem_addr, 0);
                check("rst_pmem_din", pmem_din, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
`ifdef OFIFO_DRAIN_CHECKSUM_EN
                check("rst_checksum", checksum, 0);
`endif
                m_pend.delete();
                m_active = 0; m_busy = 0; m_done = 0;
                m_pops = 0; m_n = 0; m_base = '0; m_cks = '0;
            end else begin
                exp_rd = m_active && (m_pops < m_n) && ofifo_valid && !pmem_stall;
                check("ofifo_rd", ofifo_rd, exp_rd);
                check("pmem_wr", pmem_wr, m_pend.size() != 0);
                if (m_pend.size() != 0) begin
                    check("pmem_addr", pmem_addr, m_pend[0].addr);
                    check("pmem_din", pmem_din, m_pend[0].data);
                end
                check("done", done, m_done);
                check("busy", busy, m_busy);
`ifdef OFIFO_DRAIN_CHECKSUM_EN
                check("checksum", checksum, m_cks);
                if (done) done_cks = checksum;
`endif
                if (pmem_wr && !pmem_stall) begin
                    wlog_addr.push_back(pmem_addr);
                    wlog_data.push_back(pmem_din);
                end
                if (pmem_wr) wr_hi_cnt++;
                if (done) done_cnt++;

                acc = start && !m_busy;
                if (m_pend.size() != 0 && !pmem_stall) begin
                    m_cks = m_cks ^ fold(m_pend[0].data);
                    void'(m_pend.pop_front());
                end
                if (exp_rd) begin
                    w.addr = m_base + ABW'(m_pops);
                    w.data = ofifo_out;
                    m_pend.push_back(w);
                    m_pops++;
                end
                m_done = 0;
                if (m_active && m_pops == m_n && m_pend.size() == 0) begin
                    m_active = 0;
                    m_done   = 1;
                end
                if (acc) begin
                    m_cks = '0;
                    if (num_vec == '0) begin
                        m_done = 1;
                    end else begin
                        m_active = 1;
                        m_base   = base_addr;
                        m_n      = int'(num_vec);
                        m_pops   = 0;
                    end
                end
                m_busy = m_active || m_done;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] v);
        fifo_mem[wr_ptr[7:0]] = v;
        wr_ptr++;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    // Bit i of vpat/spat drives ofifo_valid-enable / pmem_stall in cycle i after the start cycle.
    task automatic run_job(input logic [ABW-1:0] base, input logic [ABW-1:0] n,
                           input logic [15:0] vpat, input logic [15:0] spat,
                           input int restart_at, output int done_cyc);
        int d0;
        int i;
        d0 = done_cnt;
        base_addr = base; num_vec = n; start = 1'b1;
        valid_en = vpat[0]; pmem_stall = spat[0];
        step();
        start = 1'b0;
        for (i = 1; i < 40 && done_cnt == d0; i++) begin
            valid_en   = (i < 16) ? vpat[i] : 1'b1;
            pmem_stall = (i < 16) ? spat[i] : 1'b0;
            start      = (i == restart_at);
            if (i == restart_at) num_vec = 11'd7;
            step();
        end
        start = 1'b0; valid_en = 1'b1; pmem_stall = 1'b0;
        check("job_timeout", done_cnt - d0, 1);
        done_cyc = i - 1;
    endtask

    int p0, w0, h0, d0, dc;

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_vec = '0;
        pmem_stall = 1'b0; valid_en = 1'b0;
        chk_en = 1'b1;
        step(); step();
        reset = 1'b1;
        step();

        // Basic drain
        flush();
        for (int k = 1; k <= 4; k++) load(lanes(PBW'(k)));
        p0 = pops_seen; w0 = wlog_addr.size();
        run_job(11'h010, 11'd4, 16'hFFFF, 16'h0000, 0, dc);
        check("basic_pops", pops_seen - p0, 4);
        check("basic_writes", wlog_addr.size() - w0, 4);
        for (int k = 0; k < 4; k++) begin
            check("basic_addr", wlog_addr[w0+k], 11'h010 + 11'(k));
            check("basic_data", wlog_data[w0+k], lanes(PBW'(k+1)));
        end
        check("basic_done_cycle", dc, 6);
        check("basic_busy_after", busy, 0);

        // Stall on the first write
        flush();
        for (int k = 7; k <= 9; k++) load(lanes(PBW'(k)));
        p0 = pops_seen; w0 = wlog_addr.size(); h0 = wr_hi_cnt;
        run_job(11'h100, 11'd3, 16'hFFFF, 16'h000C, 0, dc);
        check("stall_pops", pops_seen - p0, 3);
        check("stall_writes", wlog_addr.size() - w0, 3);
        check("stall_wr_hi_cycles", wr_hi_cnt - h0, 5);
        check("stall_done_cycle", dc, 7);

        // OFIFO bubbles
        flush();
        for (int k = 0; k < 3; k++) load(lanes(16'h0A00 + PBW'(k)));
        p0 = pops_seen; w0 = wlog_addr.size();
        run_job(11'h020, 11'd3, 16'hFFD3, 16'h0000, 0, dc);
        check("bubble_pops", pops_seen - p0, 3);
        for (int k = 0; k < 3; k++) check("bubble_addr", wlog_addr[w0+k], 11'h020 + 11'(k));
        check("bubble_done_cycle", dc, 8);

        // Address wrap
        flush();
        for (int k = 0; k < 3; k++) load(lanes(16'h0B00 + PBW'(k)));
        w0 = wlog_addr.size();
        run_job(11'h7FE, 11'd3, 16'hFFFF, 16'h0000, 0, dc);
        check("wrap_addr0", wlog_addr[w0], 11'h7FE);
        check("wrap_addr1", wlog_addr[w0+1], 11'h7FF);
        check("wrap_addr2", wlog_addr[w0+2], 11'h000);
        check("wrap_done_cycle", dc, 5);

        // Zero-length job
        flush();
        load(lanes(16'hDEAD));
        p0 = pops_seen; w0 = wlog_addr.size(); h0 = wr_hi_cnt;
        run_job(11'h300, 11'd0, 16'hFFFF, 16'h0000, 0, dc);
        check("zero_pops", pops_seen - p0, 0);
        check("zero_wr_cycles", wr_hi_cnt - h0, 0);
        check("zero_done_cycle", dc, 1);

        // Start while busy is ignored
        flush();
        for (int k = 0; k < 8; k++) load(lanes(16'h0C00 + PBW'(k)));
        p0 = pops_seen; w0 = wlog_addr.size();
        run_job(11'h040, 11'd3, 16'hFFFF, 16'h0000, 2, dc);
        check("restart_pops", pops_seen - p0, 3);
        check("restart_writes", wlog_addr.size() - w0, 3);
        check("restart_done_cycle", dc, 5);
        step(); step();
        check("restart_no_second_job", busy, 0);

        // Reset in the middle of a job
        flush();
        for (int k = 0; k < 5; k++) load(lanes(16'h0010 + PBW'(k)));
        p0 = pops_seen; d0 = done_cnt;
        base_addr = 11'h200; num_vec = 11'd5; start = 1'b1; valid_en = 1'b1; pmem_stall = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && (pops_seen - p0) < 2; i++) step();
        check("midrst_pops_before", pops_seen - p0, 2);
        reset = 1'b0;
        #1;
        check("midrst_rd", ofifo_rd, 0);
        check("midrst_wr", pmem_wr, 0);
        check("midrst_addr", pmem_addr, 0);
        check("midrst_din", pmem_din, 0);
        check("midrst_busy", busy, 0);
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_pops_after", pops_seen - p0, 2);

        // Checksum jobs
        flush();
        load(lanes(16'h0003));
        load(lanes(16'h0005));
        run_job(11'h080, 11'd2, 16'hFFFF, 16'h0000, 0, dc);
        check("cks_job1_done_cycle", dc, 4);
`ifdef OFIFO_DRAIN_CHECKSUM_EN
        check("cks_equal_lanes", done_cks, 16'h0000);
`endif
        flush();
        load(DW'(16'h00F0));
        run_job(11'h090, 11'd1, 16'hFFFF, 16'h0000, 0, dc);
        check("cks_job2_done_cycle", dc, 3);
`ifdef OFIFO_DRAIN_CHECKSUM_EN
        check("cks_single_lane", done_cks, 16'h00F0);
`endif

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
